// File: rtl/code_lock_ctrl.sv
// Keypad code-lock controller: N-digit code check, failed-attempt lockout and in-field reprogramming.
// Optional feature: define AUTO_RELOCK_EN to relock automatically after OPEN_CYC idle cycles in OPEN.
module code_lock_ctrl #(
  parameter int unsigned CODE_LEN    = 4,
  parameter int unsigned KEY_W       = 4,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned LOCKOUT_CYC = 1000,
  parameter int unsigned OPEN_CYC    = 500,
  parameter logic [CODE_LEN*KEY_W-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [KEY_W-1:0]                  key_code,
  input  logic                              key_valid,
  output logic                              open,
  output logic                              lock,
  output logic                              save_light,
  output logic                              err,
  output logic [$clog2(MAX_TRIES+1)-1:0]    try_count,
  output logic [$clog2(CODE_LEN+1)-1:0]     digit_count
);

  localparam int unsigned CW      = CODE_LEN * KEY_W;
  localparam int unsigned TC_W    = $clog2(MAX_TRIES + 1);
  localparam int unsigned DC_W    = $clog2(CODE_LEN + 1);
  localparam int unsigned TMR_MAX = (LOCKOUT_CYC > OPEN_CYC) ? LOCKOUT_CYC : OPEN_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {
    S_LOCKED  = 2'd0,
    S_OPEN    = 2'd1,
    S_PROG    = 2'd2,
    S_LOCKOUT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     buf_q, buf_d;
  logic [CW-1:0]     code_q, code_d;
  logic [DC_W-1:0]   dc_q, dc_d;
  logic              ovf_q, ovf_d;
  logic [TC_W-1:0]   try_q, try_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              open_q, open_d;
  logic              lock_q, lock_d;
  logic              save_q, save_d;
  logic              err_q, err_d;

  logic              is_digit_c, is_clr_c, is_ent_c;
  logic              entry_ok_c, match_c, edit_c, xfer_c;
  logic [TC_W-1:0]   tries_inc_c;

  // Key decode; codes above '#' are treated as no key at all
  always_comb begin
    logic key_ok;
    key_ok      = key_valid && (key_code <= KEY_W'(11));
    is_digit_c  = key_ok && (key_code < KEY_W'(10));
    is_clr_c    = key_ok && (key_code == KEY_W'(10));
    is_ent_c    = key_ok && (key_code == KEY_W'(11));
    entry_ok_c  = (dc_q == DC_W'(CODE_LEN)) && !ovf_q;
    match_c     = (buf_q == code_q);
    tries_inc_c = try_q + TC_W'(1);
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_LOCKED;
      buf_q   <= '0;
      code_q  <= DEFAULT_CODE;
      dc_q    <= '0;
      ovf_q   <= 1'b0;
      try_q   <= '0;
      timer_q <= '0;
      open_q  <= 1'b0;
      lock_q  <= 1'b0;
      save_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      code_q  <= code_d;
      dc_q    <= dc_d;
      ovf_q   <= ovf_d;
      try_q   <= try_d;
      timer_q <= timer_d;
      open_q  <= open_d;
      lock_q  <= lock_d;
      save_q  <= save_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOCKED: begin
        if (is_ent_c) begin
          if (entry_ok_c && match_c)               state_d = S_OPEN;
          else if (tries_inc_c == TC_W'(MAX_TRIES)) state_d = S_LOCKOUT;
        end
      end
      S_LOCKOUT: begin
        if (timer_q == '0) state_d = S_LOCKED;
      end
      S_OPEN: begin
        if (is_clr_c)      state_d = S_LOCKED;
        else if (is_ent_c) state_d = S_PROG;
`ifdef AUTO_RELOCK_EN
        else if (!key_valid && (timer_q == '0)) state_d = S_LOCKED;
`endif
      end
      S_PROG: begin
        if (is_ent_c)                         state_d = S_OPEN;
        else if (is_clr_c && (dc_q == '0))    state_d = S_OPEN;
      end
      default: state_d = S_LOCKED;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    buf_d   = buf_q;
    code_d  = code_q;
    dc_d    = dc_q;
    ovf_d   = ovf_q;
    try_d   = try_q;
    timer_d = timer_q;
    err_d   = 1'b0;
    edit_c  = (state_q == S_LOCKED) || (state_q == S_PROG);
    xfer_c  = (state_d != state_q);

    if (edit_c && is_digit_c) begin
      buf_d = (buf_q << KEY_W) | CW'(key_code);
      if (dc_q == DC_W'(CODE_LEN)) ovf_d = 1'b1;
      else                         dc_d  = dc_q + DC_W'(1);
    end
    if (edit_c && is_clr_c) begin
      buf_d = '0;
      dc_d  = '0;
      ovf_d = 1'b0;
    end

    unique case (state_q)
      S_LOCKED: begin
        if (is_ent_c) begin
          if (entry_ok_c && match_c) begin
            try_d = '0;
          end else begin
            err_d = 1'b1;
            try_d = tries_inc_c;
          end
        end
      end
      S_LOCKOUT: begin
        if (timer_q == '0) try_d   = '0;
        else               timer_d = timer_q - TMR_W'(1);
      end
      S_PROG: begin
        if (is_ent_c) begin
          if (entry_ok_c) code_d = buf_q;
          else            err_d  = 1'b1;
        end
      end
      S_OPEN: begin
`ifdef AUTO_RELOCK_EN
        if (key_valid)            timer_d = TMR_W'(OPEN_CYC - 1);
        else if (timer_q != '0)   timer_d = timer_q - TMR_W'(1);
`endif
      end
      default: ;
    endcase

    // '#' in LOCKED always consumes the entry, even when staying put
    if (xfer_c || ((state_q == S_LOCKED) && is_ent_c)) begin
      buf_d = '0;
      dc_d  = '0;
      ovf_d = 1'b0;
    end
    if (xfer_c && (state_d == S_LOCKOUT)) timer_d = TMR_W'(LOCKOUT_CYC - 1);
`ifdef AUTO_RELOCK_EN
    if (xfer_c && (state_d == S_OPEN))    timer_d = TMR_W'(OPEN_CYC - 1);
`endif
  end

  // Output decode from the upcoming state
  always_comb begin
    open_d = (state_d == S_OPEN) || (state_d == S_PROG);
    lock_d = (state_d == S_LOCKOUT);
    save_d = (state_d == S_PROG);
  end

  assign open        = open_q;
  assign lock        = lock_q;
  assign save_light  = save_q;
  assign err         = err_q;
  assign try_count   = try_q;
  assign digit_count = dc_q;

endmodule
